dm_responder: RTL and testbench

//  Data-memory responder: the memory-side end of the core's DM_* interface.

---
 rtl/dm_responder.sv | 124 ++++++++++++
 tb/tb_dm_responder.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/dm_responder.sv
// Data-memory responder for the core's DM_* port: one word access at a time,
// a programmable number of wait states, then a one-cycle ready or error pulse.
module dm_responder #(
  parameter int unsigned DataSize   = 32,
  parameter int unsigned AddrSize   = 12,
  parameter int unsigned MemDepth   = 4096,
  parameter int unsigned WaitStates = 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                DM_enable,
  input  logic                DM_read,
  input  logic                DM_write,
  input  logic [AddrSize-1:0] DM_address,
  input  logic [DataSize-1:0] DM_in,
  output logic [DataSize-1:0] DM_out,
  output logic                DM_ready,
  output logic                DM_error
);

  localparam int unsigned   IdxW    = (MemDepth > 1) ? $clog2(MemDepth) : 1;
  localparam logic [2:0]    WaitCnt = 3'(WaitStates);
  localparam bit            HasWait = (WaitStates != 0);
  localparam logic [AddrSize:0] DepthL = (AddrSize + 1)'(MemDepth);

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP,
    ERR
  } state_e;

  state_e              state_q, state_d;
  logic [2:0]          cnt_q, cnt_d;
  logic                is_write_q, is_write_d;
  logic [AddrSize-1:0] addr_q, addr_d;
  logic [DataSize-1:0] data_q, data_d;
  logic [DataSize-1:0] out_q;
  logic                ready_q;
  logic                error_q;

  logic [DataSize-1:0] mem [MemDepth];

  logic                in_range_in;
  logic                in_range_q;
  logic [IdxW-1:0]     idx;

  assign in_range_in = ({1'b0, DM_address} < DepthL);
  assign in_range_q  = ({1'b0, addr_q} < DepthL);
  assign idx         = addr_q[IdxW-1:0];

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    is_write_d = is_write_q;
    addr_d     = addr_q;
    data_d     = data_q;
    unique case (state_q)
      IDLE: begin
        if (DM_enable && (DM_read ^ DM_write)) begin
          is_write_d = DM_write;
          addr_d     = DM_address;
          data_d     = DM_in;
          cnt_d      = WaitCnt;
          // With no wait states the range check must use the incoming address.
          if (HasWait)          state_d = WAIT;
          else if (in_range_in) state_d = RESP;
          else                  state_d = ERR;
        end else if (DM_enable && DM_read && DM_write) begin
          state_d = ERR;
        end
      end
      WAIT: begin
        if (cnt_q <= 3'd1) begin
          cnt_d   = '0;
          state_d = in_range_q ? RESP : ERR;
        end else begin
          cnt_d = cnt_q - 3'd1;
        end
      end
      RESP, ERR: begin
        cnt_d   = '0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Pulses are registered from the state, so they appear the cycle after RESP/ERR.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      is_write_q <= 1'b0;
      addr_q     <= '0;
      data_q     <= '0;
      out_q      <= '0;
      ready_q    <= 1'b0;
      error_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      is_write_q <= is_write_d;
      addr_q     <= addr_d;
      data_q     <= data_d;
      ready_q    <= (state_q == RESP);
      error_q    <= (state_q == ERR);
      if (state_q == RESP && !is_write_q) begin
        out_q <= mem[idx];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset && state_q == RESP && is_write_q) begin
      mem[idx] <= data_q;
    end
  end

  assign DM_out   = out_q;
  assign DM_ready = ready_q;
  assign DM_error = error_q;

endmodule

// File: tb/tb_dm_responder.sv
// Scoreboarded random bench for dm_responder: two instances (no wait states /
// deep memory, three wait states / 1024 words) share one stimulus stream.
module tb_dm_responder;

  localparam int WS0 = 0;
  localparam int DEP0 = 4096;
  localparam int WS1 = 3;
  localparam int DEP1 = 1024;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        DM_enable = 1'b0;
  logic        DM_read = 1'b0;
  logic        DM_write = 1'b0;
  logic [11:0] DM_address = '0;
  logic [31:0] DM_in = '0;
  logic [31:0] out_a, out_b;
  logic        rdy_a, rdy_b, err_a, err_b;

  always #5 clk = ~clk;

  dm_responder #(.DataSize(32), .AddrSize(12), .MemDepth(DEP0), .WaitStates(WS0)) u_dut_a (
    .clk(clk), .reset(reset), .DM_enable(DM_enable), .DM_read(DM_read), .DM_write(DM_write),
    .DM_address(DM_address), .DM_in(DM_in), .DM_out(out_a), .DM_ready(rdy_a), .DM_error(err_a)
  );

  dm_responder #(.DataSize(32), .AddrSize(12), .MemDepth(DEP1), .WaitStates(WS1)) u_dut_b (
    .clk(clk), .reset(reset), .DM_enable(DM_enable), .DM_read(DM_read), .DM_write(DM_write),
    .DM_address(DM_address), .DM_in(DM_in), .DM_out(out_b), .DM_ready(rdy_b), .DM_error(err_b)
  );

  typedef struct {
    int          cyc;
    bit          err;
    logic [31:0] dout;
    bit          chk;
  } ev_t;

  ev_t q0[$];
  ev_t q1[$];

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Reference model: per instance, a free-at cycle, one pending access and a word store.
  int          free_at[2];
  bit          pend_v[2];
  int          pend_done[2];
  bit          pend_wr[2];
  int          pend_a[2];
  logic [31:0] pend_d[2];
  logic [31:0] out_m[2];
  logic [31:0] mm[2][4096];
  bit          mk[2][4096];

  function automatic int q_size(input int i);
    return (i == 0) ? q0.size() : q1.size();
  endfunction

  function automatic ev_t q_front(input int i);
    return (i == 0) ? q0[0] : q1[0];
  endfunction

  function automatic void q_pop(input int i);
    if (i == 0) void'(q0.pop_front());
    else        void'(q1.pop_front());
  endfunction

  function automatic void q_push(input int i, input ev_t ev);
    if (i == 0) q0.push_back(ev);
    else        q1.push_back(ev);
  endfunction

  function automatic void q_cancel_from(input int i, input int k);
    if (i == 0) begin
      while (q0.size() > 0 && q0[$].cyc >= k) void'(q0.pop_back());
    end else begin
      while (q1.size() > 0 && q1[$].cyc >= k) void'(q1.pop_back());
    end
  endfunction

  // Apply the inputs present at edge k to instance i's model.
  function automatic void model_step(input int i, input int k);
    int  ws;
    int  dep;
    int  a;
    int  done;
    ev_t ev;
    ws  = (i == 0) ? WS0 : WS1;
    dep = (i == 0) ? DEP0 : DEP1;
    a   = int'(DM_address);
    if (reset) begin
      q_cancel_from(i, k);
      pend_v[i]  = 1'b0;
      out_m[i]   = '0;
      free_at[i] = k + 1;
      return;
    end
    if (pend_v[i] && k == pend_done[i]) begin
      if (pend_wr[i]) begin
        mm[i][pend_a[i]] = pend_d[i];
        mk[i][pend_a[i]] = 1'b1;
      end else begin
        out_m[i] = mm[i][pend_a[i]];
      end
      pend_v[i] = 1'b0;
    end
    if (k >= free_at[i] && DM_enable) begin
      if (DM_read && DM_write) begin
        ev = '{cyc: k + 1, err: 1'b1, dout: out_m[i], chk: 1'b1};
        q_push(i, ev);
        free_at[i] = k + 2;
      end else if (DM_read || DM_write) begin
        done       = k + 1 + ws;
        free_at[i] = done + 1;
        if (a < dep) begin
          pend_v[i]    = 1'b1;
          pend_done[i] = done;
          pend_wr[i]   = DM_write;
          pend_a[i]    = a;
          pend_d[i]    = DM_in;
          if (DM_read) ev = '{cyc: done, err: 1'b0, dout: mm[i][a], chk: mk[i][a]};
          else         ev = '{cyc: done, err: 1'b0, dout: out_m[i], chk: 1'b1};
        end else begin
          ev = '{cyc: done, err: 1'b1, dout: out_m[i], chk: 1'b1};
        end
        q_push(i, ev);
      end
    end
  endfunction

  task automatic drive(input bit rst, input bit en, input bit rd, input bit wr,
                       input logic [11:0] a, input logic [31:0] d);
    @(negedge clk);
    #1;
    reset      = rst;
    DM_enable  = en;
    DM_read    = rd;
    DM_write   = wr;
    DM_address = a;
    DM_in      = d;
    model_step(0, cyc + 1);
    model_step(1, cyc + 1);
  endtask

  task automatic idle(input int n);
    for (int j = 0; j < n; j++) drive(1'b0, 1'b0, 1'b0, 1'b0, 12'h000, 32'h0);
  endtask

  // Monitor: pulses pop the scoreboard; quiet cycles check that DM_out is held.
  logic [31:0] hold[2];
  bit          hold_known[2] = '{1'b0, 1'b0};

  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      logic        r, e;
      logic [31:0] o;
      ev_t         ev;
      r = (i == 0) ? rdy_a : rdy_b;
      e = (i == 0) ? err_a : err_b;
      o = (i == 0) ? out_a : out_b;
      while (q_size(i) > 0 && q_front(i).cyc < cyc) begin
        n_chk++;
        n_fail++;
        $display("FAIL missing_pulse dut%0d: expected at cycle %0d, still absent at cycle %0d",
                 i, q_front(i).cyc, cyc);
        q_pop(i);
      end
      if (reset) begin
        hold[i]       = '0;
        hold_known[i] = 1'b1;
        n_chk++;
        if (r !== 1'b0 || e !== 1'b0 || o !== 32'h0) begin
          n_fail++;
          $display("FAIL reset_state dut%0d cycle %0d: got rdy=%b err=%b out=%h, want 0/0/0",
                   i, cyc, r, e, o);
        end
      end else if (r === 1'b1 || e === 1'b1) begin
        n_chk++;
        if (q_size(i) == 0) begin
          n_fail++;
          $display("FAIL unexpected_pulse dut%0d cycle %0d: got rdy=%b err=%b, want none",
                   i, cyc, r, e);
        end else begin
          ev = q_front(i);
          q_pop(i);
          if (ev.cyc != cyc || ev.err != e || r === e || (ev.chk && o !== ev.dout)) begin
            n_fail++;
            $display("FAIL response dut%0d: got cycle %0d rdy=%b err=%b out=%h, want cycle %0d err=%b out=%h",
                     i, cyc, r, e, o, ev.cyc, ev.err, ev.dout);
          end
          hold[i]       = ev.dout;
          hold_known[i] = ev.chk;
        end
      end else if (hold_known[i]) begin
        n_chk++;
        if (o !== hold[i]) begin
          n_fail++;
          $display("FAIL out_hold dut%0d cycle %0d: got %h, want %h", i, cyc, o, hold[i]);
        end
      end
    end
  end

  logic [11:0] alist[8] = '{12'h000, 12'h010, 12'h020, 12'h030, 12'h3FF, 12'h400, 12'h7FF, 12'hFFF};

  initial begin
    for (int i = 0; i < 2; i++) begin
      free_at[i] = 0;
      pend_v[i]  = 1'b0;
      out_m[i]   = '0;
      for (int a = 0; a < 4096; a++) mk[i][a] = 1'b0;
    end

    for (int j = 0; j < 3; j++) drive(1'b1, 1'b0, 1'b0, 1'b0, 12'h000, 32'h0);

    for (int j = 0; j < 8; j++) begin
      drive(1'b0, 1'b1, 1'b0, 1'b1, alist[j], $urandom);
      idle(6);
    end

    drive(1'b0, 1'b1, 1'b0, 1'b1, 12'h010, 32'hDEADBEEF);
    idle(6);
    drive(1'b0, 1'b1, 1'b1, 1'b0, 12'h010, 32'h0);
    idle(8);

    for (int j = 0; j < 8; j++) begin
      logic [11:0] a;
      a = j[1] ? 12'hFFF : 12'h000;
      if (j[0]) drive(1'b0, 1'b1, 1'b1, 1'b0, a, 32'h0);
      else      drive(1'b0, 1'b1, 1'b0, 1'b1, a, j[1] ? 32'h2 : 32'h1);
    end
    idle(6);

    drive(1'b0, 1'b1, 1'b1, 1'b1, 12'h020, 32'h12345678);
    idle(6);
    drive(1'b0, 1'b1, 1'b1, 1'b0, 12'h020, 32'h0);
    idle(6);

    drive(1'b0, 1'b1, 1'b0, 1'b1, 12'h030, 32'h55);
    idle(1);
    drive(1'b1, 1'b0, 1'b0, 1'b0, 12'h000, 32'h0);
    idle(4);
    drive(1'b0, 1'b1, 1'b1, 1'b0, 12'h030, 32'h0);
    idle(6);

    drive(1'b0, 1'b1, 1'b1, 1'b0, 12'h010, 32'h0);
    idle(6);
    drive(1'b0, 1'b1, 1'b1, 1'b0, 12'h400, 32'h0);
    idle(6);

    for (int j = 0; j < 3000; j++) begin
      bit rst, en, rd, wr;
      int m;
      rst = ($urandom_range(0, 99) < 2);
      en  = ($urandom_range(0, 9) < 7);
      m   = $urandom_range(0, 9);
      rd  = (m == 1) || (m >= 2 && m <= 5);
      wr  = (m == 1) || (m >= 6);
      drive(rst, en, rd, wr, alist[$urandom_range(0, 7)], $urandom);
    end
    idle(12);

    for (int i = 0; i < 2; i++) begin
      n_chk++;
      if (q_size(i) != 0) begin
        n_fail++;
        $display("FAIL drain dut%0d: %0d responses outstanding, want 0", i, q_size(i));
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
